// File: rtl/div_pkg.sv
// Shared types and constants for the div_16 sequential signed divider.
package div_pkg;

  localparam int DIV_W = 16;
  localparam int CNT_W = 5;

  localparam logic [DIV_W-1:0] MIN_NEG  = {1'b1, {(DIV_W-1){1'b0}}};
  localparam logic [DIV_W-1:0] ALL_ONES = {DIV_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_if.sv
// Load/result handshake bundle between a requester and the div_16 divider.
interface div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
);

  logic                    load;
  logic signed [WIDTH-1:0] x;
  logic signed [WIDTH-1:0] y;
  logic signed [WIDTH-1:0] q;
  logic signed [WIDTH-1:0] r;
  logic                    ready;
  logic                    done;
  logic                    dz;
  logic                    ovf;

  modport master (
    output load, x, y,
    input  q, r, ready, done, dz, ovf
  );

  modport slave (
    input  load, x, y,
    output q, r, ready, done, dz, ovf
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             din,
  input  logic [WIDTH:0]   div_mag,
  output logic [WIDTH-1:0] rem_out,
  output logic             qbit
);

  logic [WIDTH:0] shifted;

  // The kept remainder is always below div_mag (<= 2^(WIDTH-1)), so WIDTH bits hold it.
  always_comb begin
    shifted = {rem_in, din};
    qbit    = (shifted >= div_mag);
    rem_out = qbit ? WIDTH'(shifted - div_mag) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_16.sv
// Sequential signed restoring divider, one quotient bit per clock, truncating semantics.
// Optional overflow flag for MIN_NEG / -1 is enabled by defining DIV_OVF_EN.
module div_16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic  clk,
  input  logic  res_n,
  div_if.slave  dif
);

  function automatic logic [WIDTH:0] mag(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH:0] e;
    e = {v[WIDTH-1], v};
    return v[WIDTH-1] ? -e : e;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] m);
    return neg ? -m : m;
  endfunction

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] q_q,     q_d;
  logic [WIDTH-1:0] r_q,     r_d;
  logic             dz_q,    dz_d;

  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH:0]   ay_q,    ay_d;
  logic             sx_q,    sx_d;
  logic             sy_q,    sy_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;
  logic             div_zero;

`ifdef DIV_OVF_EN
  logic             ovf_q,   ovf_d;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .din     (quo_q[WIDTH-1]),
    .div_mag (ay_q),
    .rem_out (step_rem),
    .qbit    (step_qbit)
  );

  assign div_zero = (ay_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    ay_d    = ay_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
`ifdef DIV_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (dif.load) begin
          // quo holds |x| while iterating; its MSB feeds the step and quotient bits enter at the LSB.
          sx_d  = dif.x[WIDTH-1];
          sy_d  = dif.y[WIDTH-1];
          ay_d  = mag(dif.y);
          quo_d = WIDTH'(mag(dif.x));
          rem_d = '0;
          dz_d  = 1'b0;
`ifdef DIV_OVF_EN
          ovf_d = 1'b0;
`endif
          if (dif.y != '0) begin
            state_d = CALC;
            cnt_d   = CNT_W'(WIDTH);
          end else begin
            state_d = FIX;
          end
        end
      end

      CALC: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (div_zero) begin
          // No iterations ran, so quo still holds |x| and re-signing it restores x.
          q_d  = ALL_ONES;
          r_d  = apply_sign(sx_q, quo_q);
          dz_d = 1'b1;
        end else begin
          q_d  = apply_sign(sx_q ^ sy_q, quo_q);
          r_d  = apply_sign(sx_q, rem_q);
        end
`ifdef DIV_OVF_EN
        ovf_d = sx_q & sy_q & (ay_q == (WIDTH+1)'(1)) & (quo_q == MIN_NEG);
`endif
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
`ifdef DIV_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
`ifdef DIV_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Working datapath is always reloaded on acceptance, so it carries no reset.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    ay_q  <= ay_d;
    sx_q  <= sx_d;
    sy_q  <= sy_d;
  end

  assign dif.q     = q_q;
  assign dif.r     = r_q;
  assign dif.ready = (state_q == IDLE);
  assign dif.done  = (state_q == DONE);
  assign dif.dz    = dz_q;
`ifdef DIV_OVF_EN
  assign dif.ovf   = ovf_q;
`else
  assign dif.ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_div_16.sv
// Scoreboard bench for div_16: expected results queued at load acceptance, checked on done.
module tb_div_16;
  import div_pkg::*;

  logic clk;
  logic res_n;

  div_if #(.WIDTH(DIV_W)) dif ();

  div_16 #(.WIDTH(DIV_W)) u_dut (
    .clk   (clk),
    .res_n (res_n),
    .dif   (dif)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk    = 0;
  int   n_bad    = 0;
  int   edge_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   ai;
    int   bi;
    ai    = int'($signed(a));
    bi    = int'($signed(b));
    e.dz  = 1'b0;
    e.ovf = 1'b0;
    e.acc = 0;
    if (bi == 0) begin
      e.q   = 16'hFFFF;
      e.r   = a;
      e.dz  = 1'b1;
      e.lat = 2;
    end else begin
      e.q   = 16'(ai / bi);
      e.r   = 16'(ai % bi);
      e.lat = 18;
`ifdef DIV_OVF_EN
      if (ai == -32768 && bi == -1) e.ovf = 1'b1;
`endif
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (res_n && dif.done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 16'd1, 16'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("q",   dif.q, mon_e.q);
        chk("r",   dif.r, mon_e.r);
        chk("dz",  16'(dif.dz),  16'(mon_e.dz));
        chk("ovf", 16'(dif.ovf), 16'(mon_e.ovf));
        chk("latency", 16'(edge_cnt - mon_e.acc + 1), 16'(mon_e.lat));
      end
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e     = model(a, b);
    e.acc = edge_cnt;
    sb.push_back(e);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!dif.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 16'(dif.ready), 16'd1);
  endtask

  // Called at a negedge with ready=1; load is accepted on the next posedge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    dif.load = 1'b1;
    dif.x    = a;
    dif.y    = b;
    @(posedge clk);
    #1;
    push(a, b);
    dif.load = 1'b0;
    chk("busy", 16'(dif.ready), 16'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_wait", 16'(sb.size()), 16'd0);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    wait_ready();
    issue(a, b);
    wait_idle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    res_n    = 1'b0;
    dif.load = 1'b0;
    dif.x    = '0;
    dif.y    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q",     dif.q, 16'h0000);
    chk("rst_r",     dif.r, 16'h0000);
    chk("rst_ready", 16'(dif.ready), 16'd1);
    chk("rst_done",  16'(dif.done),  16'd0);
    chk("rst_dz",    16'(dif.dz),    16'd0);
    chk("rst_ovf",   16'(dif.ovf),   16'd0);
    @(negedge clk);
    res_n = 1'b1;

    run_op(16'd100,  16'd7);
    run_op(16'hFF9C, 16'd7);
    run_op(16'd100,  16'hFFF9);

    run_op(16'd7, 16'd0);
    repeat (3) @(negedge clk);
    chk("dz_hold", 16'(dif.dz), 16'd1);
    chk("q_hold",  dif.q, 16'hFFFF);
    wait_ready();
    issue(16'd100, 16'd7);
    chk("dz_clear", 16'(dif.dz), 16'd0);
    wait_idle();

    run_op(16'h8000, 16'hFFFF);
    repeat (2) @(negedge clk);
`ifdef DIV_OVF_EN
    chk("ovf_hold", 16'(dif.ovf), 16'd1);
`else
    chk("ovf_hold", 16'(dif.ovf), 16'd0);
`endif

    // A load pulse mid-calculation must be ignored.
    wait_ready();
    issue(16'd1000, 16'd3);
    repeat (4) @(negedge clk);
    dif.load = 1'b1;
    dif.x    = 16'd9;
    dif.y    = 16'd2;
    chk("busy_calc", 16'(dif.ready), 16'd0);
    @(posedge clk);
    #1;
    dif.load = 1'b0;
    n = 0;
    @(negedge clk);
    while (!dif.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 16'(dif.done), 16'd1);
    // Load raised during the done cycle is only taken one cycle later.
    dif.load = 1'b1;
    dif.x    = 16'd50;
    dif.y    = 16'hFFFA;
    @(posedge clk);
    #1;
    chk("not_taken_in_done", 16'(dif.ready), 16'd1);
    @(posedge clk);
    #1;
    push(16'd50, 16'hFFFA);
    dif.load = 1'b0;
    chk("taken_after_done", 16'(dif.ready), 16'd0);
    wait_idle();

    // Asynchronous abort mid-calculation.
    wait_ready();
    issue(16'd500, 16'd5);
    repeat (5) @(negedge clk);
    res_n = 1'b0;
    #1;
    chk("abort_q",     dif.q, 16'h0000);
    chk("abort_r",     dif.r, 16'h0000);
    chk("abort_ready", 16'(dif.ready), 16'd1);
    chk("abort_done",  16'(dif.done),  16'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    repeat (25) @(negedge clk);
    run_op(16'd500, 16'd5);

    run_op(16'h8000, 16'h0001);
    run_op(16'h7FFF, 16'h8000);
    run_op(16'h8000, 16'h8000);
    run_op(16'h8001, 16'h0003);
    for (int i = 0; i < 8; i++) begin
      run_op(16'($urandom), 16'($urandom_range(0, 65535)));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
